// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared types and pairwise combine helper for 2x2 pooling.
// Revision    : 1.0  initial release
// ============================================================================
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Wide enough for any practical pixel width plus two guard bits.
  localparam int c_CALC_W = 32;

  function automatic int pair_sum_width(input int w);
    return w + 1;
  endfunction

  function automatic int quad_sum_width(input int w);
    return w + 2;
  endfunction

  function automatic logic signed [c_CALC_W-1:0] pair_combine(
    input pool_mode_e                  mode,
    input logic signed [c_CALC_W-1:0]  a,
    input logic signed [c_CALC_W-1:0]  b
  );
    if (mode == POOL_MAX) return (a > b) ? a : b;
    return a + b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pool_line_buffer
// Description : Register array holding horizontal pair results of even rows.
// Revision    : 1.0  initial release
// ============================================================================
module pool_line_buffer #(
  parameter int DEPTH = 10,
  parameter int WIDTH = 13,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  // Padded to a power of two so every address value is in range.
  logic [WIDTH-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/pool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : pool2x2_stream
// Description : Streaming non-overlapping 2x2 max / floor-average pooling.
// Revision    : 1.0  initial release
// ============================================================================
module pool2x2_stream
  import pool_pkg::*;
#(
  parameter int         PIXEL_BIT_WIDTH = 12,
  parameter int         IN_ROWS         = 20,
  parameter int         IN_COLS         = 20,
  parameter pool_mode_e POOL_MODE       = POOL_AVG
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_BIT_WIDTH-1:0] pixel_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [PIXEL_BIT_WIDTH-1:0] pixel_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int W  = PIXEL_BIT_WIDTH;
  localparam int PW = pair_sum_width(W);
  localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
  localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
  localparam int HALF_COLS = IN_COLS / 2;
  localparam int AW = (HALF_COLS > 1) ? $clog2(HALF_COLS) : 1;

  logic [RW-1:0]        r_row;
  logic [CW-1:0]        r_col;
  logic [W-1:0]         r_pair;
  logic [W-1:0]         r_out;
  logic                 r_out_valid;

  logic                 w_xfer_in;
  logic                 w_load;
  logic                 w_line_wr;
  logic [AW-1:0]        w_addr;
  logic [PW-1:0]        w_pair;
  logic [PW-1:0]        w_line;
  logic [W-1:0]         w_result;
  logic signed [c_CALC_W-1:0] w_held_ext;
  logic signed [c_CALC_W-1:0] w_pixel_ext;
  logic signed [c_CALC_W-1:0] w_pair_ext;
  logic signed [c_CALC_W-1:0] w_pair_wide;
  logic signed [c_CALC_W-1:0] w_line_ext;
  logic signed [c_CALC_W-1:0] w_quad_ext;
  logic                 w_unused;

  assign in_ready  = ~r_out_valid | out_ready;
  assign out_valid = r_out_valid;
  assign pixel_out = r_out;

  assign w_xfer_in = in_valid & in_ready;
  assign w_load    = w_xfer_in & r_col[0] & r_row[0];
  assign w_line_wr = w_xfer_in & r_col[0] & ~r_row[0];
  assign w_addr    = AW'(r_col >> 1);

  assign w_held_ext  = {{(c_CALC_W-W){r_pair[W-1]}}, r_pair};
  assign w_pixel_ext = {{(c_CALC_W-W){pixel_in[W-1]}}, pixel_in};
  assign w_pair_ext  = pair_combine(POOL_MODE, w_held_ext, w_pixel_ext);
  assign w_pair      = w_pair_ext[PW-1:0];

  assign w_pair_wide = {{(c_CALC_W-PW){w_pair[PW-1]}}, w_pair};
  assign w_line_ext  = {{(c_CALC_W-PW){w_line[PW-1]}}, w_line};
  assign w_quad_ext  = pair_combine(POOL_MODE, w_pair_wide, w_line_ext);

  // Average: taking bits [W+1:2] of the (W+2)-bit sum is floor(sum/4).
  assign w_result = (POOL_MODE == POOL_MAX) ? w_quad_ext[W-1:0] : w_quad_ext[W+1:2];

  assign w_unused = ^{w_pair_ext, w_quad_ext};

  pool_line_buffer #(
    .DEPTH (HALF_COLS),
    .WIDTH (PW),
    .AW    (AW)
  ) u_line_buffer (
    .clk       (clk),
    .i_wr_en   (w_line_wr),
    .i_wr_addr (w_addr),
    .i_wr_data (w_pair),
    .i_rd_addr (w_addr),
    .o_rd_data (w_line)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_pair      <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_xfer_in) begin
        if (r_col == CW'(IN_COLS - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IN_ROWS - 1)) ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (!r_col[0]) r_pair <= pixel_in;
      end
      // A fresh result wins over the clear from a simultaneous output transfer.
      if (w_load) begin
        r_out       <= w_result;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pool2x2_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool2x2_stream
// Description : Self-checking bench for pool2x2_stream against a frame model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pool2x2_stream;
  import pool_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [11:0] pixel_in;
  logic in_valid;
  logic out_ready;
  int   sel;

  logic [4:0]        rdy_v;
  logic [4:0]        ov_v;
  logic [4:0][11:0]  po_v;
  logic              in_ready;
  logic              out_valid;
  logic [11:0]       pixel_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  logic signed [11:0] stim[$];
  logic [11:0]        exp_q[$];
  logic [11:0]        got[$];
  int                 got_cyc[$];
  int                 in_cyc[$];

  always #5 clk = ~clk;

  assign in_ready  = rdy_v[sel];
  assign out_valid = ov_v[sel];
  assign pixel_out = po_v[sel];

  // 0: 4x4 avg, 1: 4x4 max, 2: 2x2 avg, 3: 20x20 avg, 4: 20x20 max
  pool2x2_stream #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(4), .IN_COLS(4), .POOL_MODE(POOL_AVG)) u_avg4 (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid && sel == 0),
    .in_ready(rdy_v[0]), .pixel_out(po_v[0]), .out_valid(ov_v[0]), .out_ready(out_ready || sel != 0));
  pool2x2_stream #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(4), .IN_COLS(4), .POOL_MODE(POOL_MAX)) u_max4 (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid && sel == 1),
    .in_ready(rdy_v[1]), .pixel_out(po_v[1]), .out_valid(ov_v[1]), .out_ready(out_ready || sel != 1));
  pool2x2_stream #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(2), .IN_COLS(2), .POOL_MODE(POOL_AVG)) u_avg2 (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid && sel == 2),
    .in_ready(rdy_v[2]), .pixel_out(po_v[2]), .out_valid(ov_v[2]), .out_ready(out_ready || sel != 2));
  pool2x2_stream #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(20), .IN_COLS(20), .POOL_MODE(POOL_AVG)) u_avg20 (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid && sel == 3),
    .in_ready(rdy_v[3]), .pixel_out(po_v[3]), .out_valid(ov_v[3]), .out_ready(out_ready || sel != 3));
  pool2x2_stream #(.PIXEL_BIT_WIDTH(12), .IN_ROWS(20), .IN_COLS(20), .POOL_MODE(POOL_MAX)) u_max20 (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .in_valid(in_valid && sel == 4),
    .in_ready(rdy_v[4]), .pixel_out(po_v[4]), .out_valid(ov_v[4]), .out_ready(out_ready || sel != 4));

  always @(negedge clk) begin
    cyc_cnt++;
    if (reset && out_valid && out_ready) begin
      got.push_back(pixel_out);
      got_cyc.push_back(cyc_cnt);
    end
    if (reset && in_valid && in_ready) in_cyc.push_back(cyc_cnt);
  end

  // Reference: each output is max or floor(mean) of a non-overlapping 2x2 block.
  function automatic void build_expected(input int rows, input int cols, input bit is_max);
    int frames;
    int base;
    int v[4];
    int s;
    exp_q.delete();
    frames = stim.size() / (rows * cols);
    for (int f = 0; f < frames; f++)
      for (int r = 0; r < rows; r += 2)
        for (int c = 0; c < cols; c += 2) begin
          base = f * rows * cols + r * cols + c;
          v[0] = int'(stim[base]);
          v[1] = int'(stim[base + 1]);
          v[2] = int'(stim[base + cols]);
          v[3] = int'(stim[base + cols + 1]);
          if (is_max) begin
            s = v[0];
            for (int k = 1; k < 4; k++) if (v[k] > s) s = v[k];
          end else begin
            s = (v[0] + v[1] + v[2] + v[3]) >>> 2;
          end
          exp_q.push_back(s[11:0]);
        end
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    pixel_in  = '0;
    reset     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    got.delete(); got_cyc.delete(); in_cyc.delete();
    @(posedge clk); #1;
  endtask

  task automatic drive(input int vpct, input int rpct, output int accepted);
    int idx = 0;
    int cyc = 0;
    while (idx < stim.size() && cyc < 30000) begin
      in_valid  = ($urandom_range(99) < vpct);
      pixel_in  = stim[idx];
      out_ready = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    accepted = idx;
  endtask

  task automatic test_reset();
    sel = 0;
    in_valid = 1'b0; out_ready = 1'b0; pixel_in = '0;
    reset = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_checks++;
    if (pixel_out !== 12'h000) begin n_fail++; $display("FAIL reset_pixel_out got=%h want=000", pixel_out); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    apply_reset();
  endtask

  task automatic test_pool_4x4();
    int acc;
    for (int m = 0; m < 2; m++) begin
      sel = m;
      apply_reset();
      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(12'(i));
      build_expected(4, 4, m == 1);
      drive(100, 100, acc);
      n_checks++;
      if (acc != 16) begin n_fail++; $display("FAIL pool4_accept mode=%0d got=%0d want=16", m, acc); end
      n_checks++;
      if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL pool4_count mode=%0d got=%0d want=%0d", m, got.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL pool4_value mode=%0d idx=%0d got=%h want=%h", m, i, got[i], exp_q[i]); end
      end
      n_checks++;
      if (got_cyc.size() < 1 || in_cyc.size() < 6 || got_cyc[0] != in_cyc[5] + 1) begin
        n_fail++;
        $display("FAIL pool4_latency mode=%0d got=%0d want=%0d", m,
                 (got_cyc.size() > 0) ? got_cyc[0] : -1, (in_cyc.size() > 5) ? in_cyc[5] + 1 : -1);
      end
    end
  endtask

  task automatic test_signed_floor();
    int acc;
    sel = 2;
    apply_reset();
    stim.delete();
    stim.push_back(-12'sd1); stim.push_back(-12'sd2); stim.push_back(-12'sd3); stim.push_back(-12'sd4);
    repeat (4) stim.push_back(12'sd2047);
    repeat (4) stim.push_back(-12'sd2048);
    build_expected(2, 2, 1'b0);
    drive(80, 80, acc);
    n_checks++;
    if (got.size() != 3) begin n_fail++; $display("FAIL signed_count got=%0d want=3", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL signed_value idx=%0d got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int cyc = 0;
    sel = 0;
    apply_reset();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(12'(i));
    build_expected(4, 4, 1'b0);
    while (idx < 16 && cyc < 200) begin
      in_valid  = 1'b1;
      pixel_in  = stim[idx];
      out_ready = (cyc >= 12);
      @(negedge clk);
      if (cyc >= 8 && cyc < 12) begin
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
        n_checks++;
        if (out_valid !== 1'b1 || pixel_out !== 12'd2) begin
          n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/002", cyc, out_valid, pixel_out);
        end
      end
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (idx != 16) begin n_fail++; $display("FAIL bp_accept got=%0d want=16", idx); end
    n_checks++;
    if (got.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got=%0d want=%0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_value idx=%0d got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx = 0;
    int cyc = 0;
    int acc;
    sel = 0;
    apply_reset();
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(12'(i));
    while (idx < 6 && cyc < 100) begin
      in_valid  = 1'b1;
      pixel_in  = stim[idx];
      out_ready = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async got=%b want=0", out_valid); end
    @(posedge clk); #1 reset = 1'b1;
    out_ready = 1'b1;
    got.delete(); got_cyc.delete(); in_cyc.delete();
    @(posedge clk); #1;
    build_expected(4, 4, 1'b0);
    drive(100, 100, acc);
    n_checks++;
    if (got.size() != 4) begin n_fail++; $display("FAIL midreset_count got=%0d want=4", got.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL midreset_value idx=%0d got=%h want=%h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    for (int m = 0; m < 2; m++) begin
      sel = 3 + m;
      apply_reset();
      stim.delete();
      for (int i = 0; i < 3 * 400; i++) stim.push_back(12'($urandom));
      build_expected(20, 20, m == 1);
      drive(70, 60, acc);
      n_checks++;
      if (acc != 1200) begin n_fail++; $display("FAIL b2b_accept mode=%0d got=%0d want=1200", m, acc); end
      n_checks++;
      if (got.size() != 300) begin n_fail++; $display("FAIL b2b_count mode=%0d got=%0d want=300", m, got.size()); end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
        n_checks++;
        if (got[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_value mode=%0d idx=%0d got=%h want=%h", m, i, got[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pool_4x4();
    test_signed_floor();
    test_backpressure();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool2x2_stream.md
# pool2x2_stream

Streaming 2×2 pooling stage placed directly downstream of `crop_plus_fifo`. It consumes the cropped window in raster order over a valid/ready handshake and emits one pooled pixel per non-overlapping 2×2 block. The output frame is IN_ROWS/2 × IN_COLS/2, also in raster order. Pooling is either max or floor-average of signed fixed-point pixels; the mode is selected by parameter.

## Interface
- PIXEL_BIT_WIDTH, 12: pixel width, signed two's complement (fraction position irrelevant to this block).
- IN_ROWS, 20: input frame rows; must be even and ≥ 2.
- IN_COLS, 20: input frame columns; must be even and ≥ 2.
- POOL_MODE, POOL_AVG: POOL_MAX or POOL_AVG (from `pool_pkg`).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pixel_in  in  PIXEL_BIT_WIDTH  input pixel, raster order.
- in_valid  in  1  pixel_in valid.
- in_ready  out  1  block accepts pixel_in this cycle.
- pixel_out  out  PIXEL_BIT_WIDTH  pooled pixel.
- out_valid  out  1  pixel_out valid.
- out_ready  in  1  downstream accepts pixel_out.

## Operation
- Input transfer: `in_valid & in_ready` at a rising edge. Output transfer: `out_valid & out_ready`.
- Counters `row` (0..IN_ROWS-1) and `col` (0..IN_COLS-1) advance on each input transfer. `col` wraps to 0 and increments `row`. After (IN_ROWS-1, IN_COLS-1) both return to 0. The next frame follows with no gap and no sideband signal.
- Pair register holds the even-column pixel. On an odd-column pixel, the pair result is formed:
  - POOL_MAX: the signed max.
  - POOL_AVG: the sign-extended sum, width W+1.
- Even row: the pair result is written to `line_buf[col>>1]` (depth IN_COLS/2, width W+1).
- Odd row: the pair result is combined with `line_buf[col>>1]`:
  - POOL_MAX: signed max of the two.
  - POOL_AVG: the (W+2)-bit sum is arithmetically shifted right by 2 (floor, not round-to-nearest) and truncated to W bits. The value always fits; no saturation is needed.
- The result is loaded into the single-entry output register, which sets out_valid.
- `in_ready = ~out_valid | out_ready`, unconditionally, including on pixels that do not produce output. This is intentionally conservative and keeps the logic simple.
- No output is produced for even rows or even columns.

## Timing
- Reset values: out_valid=0, pixel_out=0, row=0, col=0, pair register=0. line_buf contents are don't-care (they are always written before being read).
- in_ready is 1 during reset deassertion (because out_valid=0).
- Latency: pixel_out/out_valid are asserted the cycle after the transfer of the block's bottom-right pixel (odd row, odd col).
- Output register:
  - Holds value and out_valid stable while out_ready=0.
  - Clears on an output transfer unless a new result loads in the same edge. A new result is possible the same edge because in_ready=1 via out_ready. A load takes priority and out_valid stays 1.
- Throughput: one input per cycle when out_ready is held at 1. Maximum output rate is one per 2 cycles.
- Reset assertion mid-frame discards the partial frame and the pending output immediately (asynchronous). The first transfer after release is treated as pixel (0,0).
- Frame wrap: the last pixel of frame N and the first pixel of frame N+1 on consecutive cycles need no special handling.

## Structure
- `pool_pkg`: `pool_mode_e` {POOL_MAX, POOL_AVG}; localparam helpers for sum widths (W+1, W+2); a `pair_combine` function (max / add) shared by both pooling levels.
- Sub-module `pool_line_buffer`: a register array of depth IN_COLS/2, with one write port and one combinational read port addressed by `col>>1`.
- Top: counters, pair register, combine logic, output register. The target implementation size is ~150–250 lines.

## Test plan
- 4×4 frame, POOL_AVG, pixels 0..15 in raster order, out_ready=1 → outputs 2, 4, 10, 12 in order.
- Same stimulus with POOL_MAX → outputs 5, 7, 13, 15.
- Signed floor check, 2×2 frame, POOL_AVG:
  - -1, -2, -3, -4 → -3 (0xFFD for W=12).
  - 2047, 2047, 2047, 2047 → 2047.
  - -2048 ×4 → -2048.
- Backpressure: hold out_ready=0 after the first output → in_ready falls to 0 and pixel_out stays 2 until out_ready=1. The sequence is completed with no loss or duplication.
- Reset pulse after 6 pixels of a 4×4 frame, then feed 0..15 → exactly 2, 4, 10, 12. Nothing is emitted from the aborted frame.
- Randomised in_valid/out_ready, 20×20 frames back-to-back ×3 → 300 outputs total, matching the golden model bit-exactly.
